// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction fetch stage: fetch FSM states,
// opcode field position and the default reset PC.
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } fetch_state_e;

  localparam int          OPC_MSB          = 31;
  localparam int          OPC_LSB          = 26;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Clears the two byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset to RESET_PC, load on redirect, step by 4.
// Load takes priority over increment; arithmetic wraps modulo 2^32.
module fetch_pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic [31:0] load_pc,
  input  logic        inc_en,
  output logic [31:0] pc,
  output logic [31:0] pc_next_seq
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  assign pc_next_seq = pc_q + 32'd4;
  assign pc          = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = word_align(load_pc);
    end else if (inc_en) begin
      pc_d = pc_next_seq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= word_align(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding imem request, sequential PC+4,
// downstream redirects. Build with FETCH_ALIGN_CHK_EN to halt on misaligned targets.
//
// state | meaning
// IDLE  | just out of reset, no request
// REQ   | imem_req high at pc, waiting for imem_ready
// WAIT  | request accepted, waiting for imem_rvalid (drop discards it)
// HOLD  | instruction presented to decode until id_ready
// HALT  | misaligned redirect seen, frozen until reset
module inst_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [5:0]  opcode,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4,
  input  logic        id_ready,
`ifdef FETCH_ALIGN_CHK_EN
  output logic        fetch_misalign,
`endif
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target
);

  fetch_state_e state_q, state_d;
  logic         drop_q, drop_d;
  logic         inst_valid_q, inst_valid_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic [31:0]  pc_plus4_q, pc_plus4_d;
  logic         redir_act;
  logic         pc_load;
  logic         pc_inc;
  logic [31:0]  pc;
  logic [31:0]  pc_seq;
`ifdef FETCH_ALIGN_CHK_EN
  logic         misalign_q, misalign_d;
`endif

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (pc_load),
    .load_pc     (redirect_target),
    .inc_en      (pc_inc),
    .pc          (pc),
    .pc_next_seq (pc_seq)
  );

  assign redir_act = redirect_valid && (state_q != IDLE) && (state_q != HALT);

  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    pc_plus4_d   = pc_plus4_q;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    misalign_d   = misalign_q;
`endif
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ready) begin
          state_d = WAIT;
          drop_d  = redir_act;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = REQ;
          drop_d  = 1'b0;
          if (!drop_q && !redir_act) begin
            inst_d       = imem_rdata;
            inst_pc_d    = pc;
            pc_plus4_d   = pc_seq;
            inst_valid_d = 1'b1;
            pc_inc       = 1'b1;
            state_d      = HOLD;
          end
        end else if (redir_act) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (id_ready || redir_act) begin
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
    // A redirect squashes whatever is held; the state-specific part is above.
    if (redir_act) begin
      pc_load      = 1'b1;
      inst_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
      if (redirect_target[1:0] != 2'b00) begin
        misalign_d = 1'b1;
        drop_d     = 1'b0;
        state_d    = HALT;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      pc_plus4_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      pc_plus4_q   <= pc_plus4_d;
    end
  end

`ifdef FETCH_ALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign fetch_misalign = misalign_q;
`endif

  assign imem_req   = (state_q == REQ);
  assign imem_addr  = pc;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign opcode     = inst_q[OPC_MSB:OPC_LSB];
  assign inst_pc    = inst_pc_q;
  assign pc_plus4   = pc_plus4_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: sequential fetch, decode stall, redirects in
// every state, PC wrap, misaligned target and reset mid-operation.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [5:0]  opcode;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
`ifdef FETCH_ALIGN_CHK_EN
  logic        fetch_misalign;
`endif

  int tests_run;
  int tests_failed;

  inst_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .opcode          (opcode),
    .inst_pc         (inst_pc),
    .pc_plus4        (pc_plus4),
    .id_ready        (id_ready),
`ifdef FETCH_ALIGN_CHK_EN
    .fetch_misalign  (fetch_misalign),
`endif
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    rst_n           = 1'b0;
    imem_ready      = 1'b1;
    imem_rvalid     = 1'b0;
    imem_rdata      = 32'h0;
    id_ready        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    #2;
    check("rst_req",      {31'b0, imem_req},   32'h0);
    check("rst_addr",     imem_addr,           32'h0);
    check("rst_ivalid",   {31'b0, inst_valid}, 32'h0);
    check("rst_inst",     inst,                32'h0);
    check("rst_opcode",   {26'b0, opcode},     32'h0);
    check("rst_inst_pc",  inst_pc,             32'h0);
    check("rst_pc_plus4", pc_plus4,            32'h0);
`ifdef FETCH_ALIGN_CHK_EN
    check("rst_misalign", {31'b0, fetch_misalign}, 32'h0);
`endif
    step();
    step();
    rst_n = 1'b1;

    // IDLE -> REQ at 0
    step();
    check("req0_req",  {31'b0, imem_req}, 32'h1);
    check("req0_addr", imem_addr,         32'h0);
    step();
    check("wait0_req", {31'b0, imem_req}, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h2008_0005;
    step();
    imem_rvalid = 1'b0;
    check("hold0_valid",  {31'b0, inst_valid}, 32'h1);
    check("hold0_inst",   inst,                32'h2008_0005);
    check("hold0_opcode", {26'b0, opcode},     32'h0000_0008);
    check("hold0_pc",     inst_pc,             32'h0);
    check("hold0_pc4",    pc_plus4,            32'h4);

    // decode stall for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", {31'b0, inst_valid}, 32'h1);
      check("stall_inst",  inst,                32'h2008_0005);
      check("stall_pc",    inst_pc,             32'h0);
      check("stall_req",   {31'b0, imem_req},   32'h0);
    end
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    check("req4_req",   {31'b0, imem_req},   32'h1);
    check("req4_addr",  imem_addr,           32'h4);
    check("req4_valid", {31'b0, inst_valid}, 32'h0);
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h2009_0007;
    step();
    imem_rvalid = 1'b0;
    check("hold4_pc",  inst_pc,  32'h4);
    check("hold4_pc4", pc_plus4, 32'h8);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    check("req8_addr", imem_addr, 32'h8);

    // redirect in WAIT, data arrives two cycles later and is dropped
    step();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    check("rw_req", {31'b0, imem_req}, 32'h0);
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    check("rw_valid", {31'b0, inst_valid}, 32'h0);
    check("rw_req2",  {31'b0, imem_req},   32'h1);
    check("rw_addr",  imem_addr,           32'h40);
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h8C09_0004;
    step();
    imem_rvalid = 1'b0;
    check("h40_inst",   inst,            32'h8C09_0004);
    check("h40_opcode", {26'b0, opcode}, 32'h0000_0023);
    check("h40_pc",     inst_pc,         32'h40);

    // redirect in HOLD with id_ready in the same cycle
    id_ready        = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0100;
    step();
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    check("rh_valid", {31'b0, inst_valid}, 32'h0);
    check("rh_addr",  imem_addr,           32'h100);
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0000;
    step();
    imem_rvalid = 1'b0;
    check("h100_opcode", {26'b0, opcode}, 32'h0);
    check("h100_pc4",    pc_plus4,        32'h104);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;

    // REQ stall without ready; stray rvalid ignored; redirect while unaccepted
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    step();
    imem_rvalid = 1'b0;
    check("stall_addr",  imem_addr,           32'h104);
    check("stray_valid", {31'b0, inst_valid}, 32'h0);
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("rr_req",  {31'b0, imem_req}, 32'h1);
    check("rr_addr", imem_addr,         32'hFFFF_FFFC);
    imem_ready = 1'b1;
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0800_0010;
    step();
    imem_rvalid = 1'b0;
    check("wrap_pc",     inst_pc,         32'hFFFF_FFFC);
    check("wrap_pc4",    pc_plus4,        32'h0);
    check("wrap_opcode", {26'b0, opcode}, 32'h2);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    check("wrap_addr", imem_addr, 32'h0);

    // redirect in REQ accepted the same cycle: response dropped
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    check("ra_req", {31'b0, imem_req}, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    step();
    imem_rvalid = 1'b0;
    check("ra_valid", {31'b0, inst_valid}, 32'h0);
    check("ra_addr",  imem_addr,           32'h200);

    // misaligned redirect target
    imem_ready      = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0042;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    check("mis_flag", {31'b0, fetch_misalign}, 32'h1);
    check("mis_req",  {31'b0, imem_req},       32'h0);
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt_req",  {31'b0, imem_req},       32'h0);
      check("halt_flag", {31'b0, fetch_misalign}, 32'h1);
    end
    rst_n = 1'b0;
    #1;
    check("halt_rst_flag", {31'b0, fetch_misalign}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check("halt_exit_req", {31'b0, imem_req}, 32'h1);
`else
    check("mask_req",  {31'b0, imem_req}, 32'h1);
    check("mask_addr", imem_addr,         32'h40);
    imem_ready = 1'b1;
`endif

    // reset mid-operation; late rvalid for the old request is ignored
    step();
    check("mr_wait_req", {31'b0, imem_req}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("mr_addr",  imem_addr,         32'h0);
    check("mr_req",   {31'b0, imem_req}, 32'h0);
    step();
    rst_n       = 1'b1;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hCAFE_F00D;
    step();
    check("mr_valid1", {31'b0, inst_valid}, 32'h0);
    check("mr_req1",   {31'b0, imem_req},   32'h1);
    step();
    imem_rvalid = 1'b0;
    check("mr_valid2", {31'b0, inst_valid}, 32'h0);
    check("mr_inst",   inst,                32'h0);
    check("mr_addr2",  imem_addr,           32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage for the 32-bit MIPS core.
- Owns the PC and requests words from instruction memory.
- Presents each fetched instruction, with its opcode field, to the decode/Control stage.
- Accepts branch/jump redirects resolved downstream.
- Single outstanding memory request; no speculation beyond sequential PC+4.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; low 2 bits must be 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address.
- imem_ready  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  read data valid (earliest one cycle after acceptance).
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  inst/opcode/inst_pc hold a valid instruction.
- inst  out  32  fetched instruction.
- opcode  out  6  inst[31:26], the field the Control decoder consumes.
- inst_pc  out  32  address of inst.
- pc_plus4  out  32  inst_pc + 4, for branch/jump target calculation.
- id_ready  in  1  decode consumes inst this cycle when inst_valid=1.
- redirect_valid  in  1  taken branch or jump.
- redirect_target  in  32  new PC.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, pc=RESET_PC, drop=0, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, pc_plus4=0.
- IDLE: imem_req=0. Moves to REQ the first cycle after reset deasserts.
- REQ: imem_req=1, imem_addr=pc. On imem_ready, move to WAIT. imem_addr may change while unaccepted, on redirect only.
- WAIT: imem_req=0. On imem_rvalid:
  - drop=1: discard data, clear drop, go to REQ.
  - drop=0: register inst=imem_rdata, inst_pc=pc, pc_plus4=pc+4, inst_valid=1, pc<=pc+4, go to HOLD.
- HOLD: inst_valid=1, outputs stable. On id_ready: inst_valid<=0, go to REQ.
- Throughput: 1 instruction per 3 cycles with 1-cycle memory (REQ, WAIT, HOLD).
- Redirect (highest priority, any state except IDLE):
  - pc <= {redirect_target[31:2], 2'b00}.
  - inst_valid <= 0 next cycle; the held instruction is squashed even if id_ready is asserted the same cycle.
  - REQ with imem_ready in the same cycle: request counts as accepted; go to WAIT with drop=1.
  - REQ without imem_ready: stay in REQ; new address appears next cycle.
  - WAIT: drop <= 1, unless imem_rvalid arrives the same cycle, in which case the data is discarded and the FSM goes to REQ.
  - HOLD: go to REQ.
- PC arithmetic: modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- opcode is combinationally inst[31:26]. It is 0 whenever inst is 0.
- Reset mid-operation: immediate return to reset values; any later imem_rvalid for a pre-reset request is ignored, because the FSM is in IDLE/REQ.
- imem_rvalid outside WAIT is ignored.

Optional Feature:
- Macro: FETCH_ALIGN_CHK_EN.
- Defined:
  - Adds output fetch_misalign (1 bit, reset 0).
  - A redirect with target[1:0]!=0 sets fetch_misalign=1 (sticky) and moves the FSM to HALT.
  - HALT: imem_req=0, inst_valid=0. Left only by reset.
- Undefined:
  - No port.
  - target low bits are silently masked as described above.

Decomposition:
- Shared package mips_pkg: fetch state enum (IDLE, REQ, WAIT, HOLD, HALT), opcode field position constants (OPC_MSB=31, OPC_LSB=26), the default reset PC constant.
- One natural sub-module, fetch_pc_reg: PC register with load/increment/reset, and a next-PC mux (redirect vs +4).

Test Plan:
- Reset release, imem always ready, 1-cycle rvalid, rdata=32'h2008_0005 -> imem_addr=0, then 4, 8; first inst_valid with inst=32'h2008_0005, opcode=6'b001000, inst_pc=0, pc_plus4=4.
- id_ready held 0 for 5 cycles in HOLD -> inst/inst_pc stable, no new imem_req; id_ready=1 -> request to next address on the following cycle.
- Redirect to 32'h0000_0040 while in WAIT; rvalid arrives 2 cycles later with 32'hDEAD_BEEF -> data dropped, inst_valid stays 0, next request addr=32'h40.
- Redirect to 32'h100 in HOLD with id_ready=1 the same cycle -> inst squashed, next imem_addr=32'h100.
- Redirect to 32'hFFFF_FFFC, fetch twice -> second imem_addr=32'h0000_0000.
- Redirect to 32'h0000_0042:
  - with FETCH_ALIGN_CHK_EN: fetch_misalign=1, imem_req=0 until rst_n pulse.
  - without it: imem_addr=32'h40.
